acquisition_sequencer: RTL and testbench



---
 rtl/acq_pkg.sv | 38 +++
 rtl/integ_timer.sv | 44 ++++
 rtl/acquisition_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_acquisition_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// ---------------------------------------------------------------------------
// acq_pkg
// Shared definitions for the acquisition sequencer slice.
//   - default parameter values used by the top level
//   - opcode encodings of the USB command word (3-bit opcode field)
//   - FSM state encoding (2 bits)
//   - valWidth(): derives the width of the command value field
// ---------------------------------------------------------------------------
package acq_pkg;

    localparam int CMD_WIDTH_DEF     = 16;
    localparam int OP_WIDTH_DEF      = 3;
    localparam int NUM_CH_DEF        = 4;
    localparam int CNT_WIDTH_DEF     = 32;
    localparam int INTEG_SHIFT_DEF   = 2;
    localparam int DEFAULT_INTEG_DEF = 5000;

    localparam logic [2:0] OP_NOOP       = 3'd0;
    localparam logic [2:0] OP_START      = 3'd1;
    localparam logic [2:0] OP_STOP       = 3'd2;
    localparam logic [2:0] OP_SET_INTEG  = 3'd3;
    localparam logic [2:0] OP_SET_FRAMES = 3'd4;
    localparam logic [2:0] OP_SET_MASK   = 3'd5;
    localparam logic [2:0] OP_SINGLE     = 3'd6;
    localparam logic [2:0] OP_CLR_ERR    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INTEGRATE = 2'd1,
        ST_READOUT   = 2'd2
    } acqState_t;

    // The value field is whatever is left of the command word below the opcode.
    function automatic int valWidth(input int cmdWidth, input int opWidth);
        return cmdWidth - opWidth;
    endfunction

endpackage

// File: rtl/integ_timer.sv
// ---------------------------------------------------------------------------
// integ_timer
// Loadable down-counter that times the integration window.
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous active-high reset
//   load_i       load loadValue_i into the counter (has priority)
//   enable_i     decrement the counter this cycle
//   loadValue_i  integration length in clock cycles
//   terminal_o   high while enabled and the counter holds 1, i.e. the last
//                integration cycle
// ---------------------------------------------------------------------------
module integ_timer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic                 enable_i,
    input  logic [CNT_WIDTH-1:0] loadValue_i,
    output logic                 terminal_o
);

    logic [CNT_WIDTH-1:0] count_q;

    // Load wins over decrement so a frame can be re-armed in the same cycle
    // the previous one finishes; the counter parks at zero instead of wrapping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadValue_i;
        end else if (enable_i && (count_q != '0)) begin
            count_q <= count_q - CNT_WIDTH'(1);
        end
    end

    // The terminal flag marks the cycle in which the owner must leave the
    // integration phase, so it is only meaningful while counting.
    always_comb begin
        terminal_o = enable_i && (count_q == CNT_WIDTH'(1));
    end

endmodule

// File: rtl/acquisition_sequencer.sv
// ---------------------------------------------------------------------------
// acquisition_sequencer
// Decodes opcode/value command words from the USB controller, holds the
// integration/frame configuration and sequences integrate -> readout frames
// over NUM_CH readout channels (single-shot, finite-count, continuous).
// Ports:
//   clk_in        system clock
//   reset         asynchronous active-high reset
//   cmd_word      {opcode, value}; opcode in the OP_WIDTH MSBs
//   cmd_valid     single-cycle strobe qualifying cmd_word
//   readout_done  per-channel done pulse from the readout controllers
//   start_ch      one-cycle start pulse per enabled channel
//   running       high whenever the sequencer is not idle
//   integ_count   current integration length in clock cycles
//   frame_count   frames completed since the last START/SINGLE (saturating)
//   cmd_error     sticky illegal-command flag
// ---------------------------------------------------------------------------
module acquisition_sequencer
    import acq_pkg::*;
#(
    parameter int CMD_WIDTH     = CMD_WIDTH_DEF,
    parameter int OP_WIDTH      = OP_WIDTH_DEF,
    parameter int NUM_CH        = NUM_CH_DEF,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter int INTEG_SHIFT   = INTEG_SHIFT_DEF,
    parameter int DEFAULT_INTEG = DEFAULT_INTEG_DEF
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [CMD_WIDTH-1:0] cmd_word,
    input  logic                 cmd_valid,
    input  logic [NUM_CH-1:0]    readout_done,
    output logic [NUM_CH-1:0]    start_ch,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] integ_count,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic                 cmd_error
);

    localparam int VAL_WIDTH = valWidth(CMD_WIDTH, OP_WIDTH);

    acqState_t            state_q;
    logic [NUM_CH-1:0]    startCh_q;
    logic                 running_q;
    logic [CNT_WIDTH-1:0] integCount_q;
    logic [CNT_WIDTH-1:0] frameCount_q;
    logic                 cmdError_q;
    logic [NUM_CH-1:0]    chMask_q;
    logic [CNT_WIDTH-1:0] frameTarget_q;
    logic                 continuous_q;
    logic [NUM_CH-1:0]    pending_q;
    logic                 stopReq_q;

    logic [OP_WIDTH-1:0]  opcode;
    logic [VAL_WIDTH-1:0] cmdValue;
    logic isStart, isStop, isSetInteg, isSetFrames, isSetMask, isSingle, isClrErr;

    logic [CNT_WIDTH-1:0] integShifted;
    logic [CNT_WIDTH-1:0] integCount_d;
    logic [CNT_WIDTH-1:0] frameCount_d;
    logic [NUM_CH-1:0]    pending_d;
    logic                 cmdError_d;
    logic                 frameDone;
    logic                 moreFrames;
    logic                 continueFrame;
    logic                 startOk;
    logic                 timerLoad;
    logic                 timerDone;

    assign opcode   = cmd_word[CMD_WIDTH-1 -: OP_WIDTH];
    assign cmdValue = cmd_word[VAL_WIDTH-1:0];

    // One-hot command strobes; nothing is decoded unless cmd_valid qualifies it.
    always_comb begin
        isStart     = 1'b0;
        isStop      = 1'b0;
        isSetInteg  = 1'b0;
        isSetFrames = 1'b0;
        isSetMask   = 1'b0;
        isSingle    = 1'b0;
        isClrErr    = 1'b0;
        if (cmd_valid) begin
            case (opcode)
                OP_WIDTH'(OP_NOOP):       ;
                OP_WIDTH'(OP_START):      isStart     = 1'b1;
                OP_WIDTH'(OP_STOP):       isStop      = 1'b1;
                OP_WIDTH'(OP_SET_INTEG):  isSetInteg  = 1'b1;
                OP_WIDTH'(OP_SET_FRAMES): isSetFrames = 1'b1;
                OP_WIDTH'(OP_SET_MASK):   isSetMask   = 1'b1;
                OP_WIDTH'(OP_SINGLE):     isSingle    = 1'b1;
                OP_WIDTH'(OP_CLR_ERR):    isClrErr    = 1'b1;
                default:                  ;
            endcase
        end
    end

    // Next-value helpers shared by the FSM and the timer control. A zero
    // integration length would never reach the terminal count, so it is
    // clamped to one cycle. The frame-target test is done one bit wider so
    // that frame_count+1 cannot wrap when the count is saturated. Errors win
    // over CLR_ERR arriving in the same cycle.
    always_comb begin
        integShifted = CNT_WIDTH'(cmdValue) << INTEG_SHIFT;
        integCount_d = (integShifted == '0) ? CNT_WIDTH'(1) : integShifted;
        frameCount_d = (frameCount_q == '1) ? frameCount_q : frameCount_q + CNT_WIDTH'(1);
        pending_d    = pending_q & ~readout_done;
        frameDone    = (state_q == ST_READOUT) && (pending_d == '0);
        moreFrames   = (frameTarget_q == '0) ||
                       (({1'b0, frameCount_q} + (CNT_WIDTH+1)'(1)) < {1'b0, frameTarget_q});
        continueFrame = frameDone && continuous_q && !(stopReq_q || isStop) && moreFrames;
        startOk      = (state_q == ST_IDLE) && (isStart || isSingle) && (chMask_q != '0);
        timerLoad    = startOk || continueFrame;

        cmdError_d = cmdError_q;
        if (isClrErr) begin
            cmdError_d = 1'b0;
        end
        if (((state_q != ST_IDLE) && (isSetInteg || isSetFrames || isSetMask || isStart || isSingle)) ||
            ((state_q == ST_IDLE) && (isStart || isSingle) && (chMask_q == '0))) begin
            cmdError_d = 1'b1;
        end
    end

    integ_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_integ_timer (
        .clk_i       (clk_in),
        .reset_i     (reset),
        .load_i      (timerLoad),
        .enable_i    (state_q == ST_INTEGRATE),
        .loadValue_i (integCount_q),
        .terminal_o  (timerDone)
    );

    // Main sequencer. Configuration writes are only accepted while idle.
    // In INTEGRATE a STOP beats the terminal count, so no start pulse is
    // issued. In READOUT a STOP is only latched: the frame in flight still
    // finishes and counts before returning to idle. The start pulse is
    // cleared every cycle and only set on the INTEGRATE -> READOUT edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            startCh_q     <= '0;
            running_q     <= 1'b0;
            integCount_q  <= CNT_WIDTH'(DEFAULT_INTEG);
            frameCount_q  <= '0;
            cmdError_q    <= 1'b0;
            chMask_q      <= '1;
            frameTarget_q <= '0;
            continuous_q  <= 1'b0;
            pending_q     <= '0;
            stopReq_q     <= 1'b0;
        end else begin
            startCh_q  <= '0;
            cmdError_q <= cmdError_d;
            case (state_q)
                ST_IDLE: begin
                    if (isSetInteg) begin
                        integCount_q <= integCount_d;
                    end
                    if (isSetFrames) begin
                        frameTarget_q <= CNT_WIDTH'(cmdValue);
                    end
                    if (isSetMask) begin
                        chMask_q <= cmdValue[NUM_CH-1:0];
                    end
                    if (startOk) begin
                        state_q      <= ST_INTEGRATE;
                        running_q    <= 1'b1;
                        frameCount_q <= '0;
                        pending_q    <= '0;
                        continuous_q <= isStart;
                        stopReq_q    <= 1'b0;
                    end
                end
                ST_INTEGRATE: begin
                    if (isStop) begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end else if (timerDone) begin
                        state_q   <= ST_READOUT;
                        startCh_q <= chMask_q;
                        pending_q <= chMask_q;
                    end
                end
                ST_READOUT: begin
                    pending_q <= pending_d;
                    if (isStop) begin
                        stopReq_q <= 1'b1;
                    end
                    if (frameDone) begin
                        frameCount_q <= frameCount_d;
                        if (continueFrame) begin
                            state_q <= ST_INTEGRATE;
                        end else begin
                            state_q   <= ST_IDLE;
                            running_q <= 1'b0;
                            stopReq_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign start_ch    = startCh_q;
    assign running     = running_q;
    assign integ_count = integCount_q;
    assign frame_count = frameCount_q;
    assign cmd_error   = cmdError_q;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// ---------------------------------------------------------------------------
// tb_acquisition_sequencer
// Self-checking bench for acquisition_sequencer (default parameters).
// A schedule-based reference model predicts every output after every clock
// edge; a table of single-cycle command vectors and hand-written multi-cycle
// sequences add explicit expectations; a randomized phase closes out.
// ---------------------------------------------------------------------------
module tb_acquisition_sequencer;

    localparam int PH_IDLE = 0;
    localparam int PH_INT  = 1;
    localparam int PH_RO   = 2;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [15:0] cmd_word;
    logic        cmd_valid;
    logic [3:0]  readout_done;
    logic [3:0]  start_ch;
    logic        running;
    logic [31:0] integ_count;
    logic [31:0] frame_count;
    logic        cmd_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] cmd;
        logic        valid;
        logic [3:0]  done;
        logic [3:0]  expStart;
        logic        expRunning;
        logic [31:0] expInteg;
        logic [31:0] expFrames;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    int          mPhase;
    int unsigned mInteg;
    int unsigned mTarget;
    int unsigned mFrames;
    logic [3:0]  mMask;
    logic [3:0]  mOutstanding;
    logic [3:0]  mStart;
    bit          mCont;
    bit          mStopLatched;
    bit          mErr;
    longint      edgeNum;
    longint      mPulseAt;

    // Free-running clock, 10 time units per cycle.
    always #5 clk_in = ~clk_in;

    acquisition_sequencer dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .cmd_word     (cmd_word),
        .cmd_valid    (cmd_valid),
        .readout_done (readout_done),
        .start_ch     (start_ch),
        .running      (running),
        .integ_count  (integ_count),
        .frame_count  (frame_count),
        .cmd_error    (cmd_error)
    );

    // Global watchdog so a stuck run still ends with a report.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] mkCmd(input int op, input int val);
        logic [15:0] w;
        w = {op[2:0], val[12:0]};
        return w;
    endfunction

    task automatic addVec(input string name, input int op, input int val, input logic [3:0] eStart,
                          input logic eRun, input int unsigned eInteg, input int unsigned eFrames,
                          input logic eErr);
        vec_t v;
        v.name       = name;
        v.cmd        = mkCmd(op, val);
        v.valid      = 1'b1;
        v.done       = 4'b0;
        v.expStart   = eStart;
        v.expRunning = eRun;
        v.expInteg   = eInteg;
        v.expFrames  = eFrames;
        v.expErr     = eErr;
        vecs.push_back(v);
    endtask

    task automatic modelReset();
        mPhase       = PH_IDLE;
        mInteg       = 5000;
        mTarget      = 0;
        mFrames      = 0;
        mMask        = 4'hF;
        mOutstanding = 4'h0;
        mStart       = 4'h0;
        mCont        = 1'b0;
        mStopLatched = 1'b0;
        mErr         = 1'b0;
    endtask

    // Reference model: advances one clock edge. Frames are scheduled by the
    // absolute edge at which their start pulse appears (command edge plus
    // the integration length) rather than by a counter.
    task automatic modelStep(input logic [15:0] cmd, input logic valid, input logic [3:0] done);
        int          op;
        int unsigned val;
        bit          isCfg;
        bit          isGo;
        bit          isStopC;
        bit          newErr;
        op      = int'(cmd[15:13]);
        val     = int'(cmd[12:0]);
        isCfg   = valid && (op == 3 || op == 4 || op == 5);
        isGo    = valid && (op == 1 || op == 6);
        isStopC = valid && (op == 2);
        newErr  = 1'b0;
        mStart  = 4'h0;
        edgeNum++;
        if (mPhase == PH_IDLE) begin
            if (valid && op == 3) mInteg = (val * 4 == 0) ? 1 : val * 4;
            if (valid && op == 4) mTarget = val;
            if (valid && op == 5) mMask = cmd[3:0];
            if (isGo) begin
                if (mMask == 4'h0) begin
                    newErr = 1'b1;
                end else begin
                    mPhase       = PH_INT;
                    mPulseAt     = edgeNum + longint'(mInteg);
                    mFrames      = 0;
                    mCont        = (op == 1);
                    mStopLatched = 1'b0;
                end
            end
        end else begin
            if (isCfg || isGo) newErr = 1'b1;
            if (mPhase == PH_INT) begin
                if (isStopC) begin
                    mPhase = PH_IDLE;
                end else if (edgeNum == mPulseAt) begin
                    mPhase       = PH_RO;
                    mStart       = mMask;
                    mOutstanding = mMask;
                end
            end else begin
                if (isStopC) mStopLatched = 1'b1;
                mOutstanding = mOutstanding & ~done;
                if (mOutstanding == 4'h0) begin
                    if (mFrames != 32'hFFFF_FFFF) mFrames++;
                    if (mCont && !mStopLatched && (mTarget == 0 || mFrames < mTarget)) begin
                        mPhase   = PH_INT;
                        mPulseAt = edgeNum + longint'(mInteg);
                    end else begin
                        mPhase = PH_IDLE;
                    end
                end
            end
        end
        if (newErr) mErr = 1'b1;
        else if (valid && op == 7) mErr = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, actual, expected, edgeNum);
        end
    endtask

    task automatic checkModel();
        checkOutput("model_start_ch",    32'(start_ch),    32'(mStart));
        checkOutput("model_running",     32'(running),     32'(mPhase != PH_IDLE));
        checkOutput("model_integ_count", integ_count,      mInteg);
        checkOutput("model_frame_count", frame_count,      mFrames);
        checkOutput("model_cmd_error",   32'(cmd_error),   32'(mErr));
    endtask

    // Drives one cycle of inputs (called #1 after a rising edge), lets the
    // DUT take the next edge, then compares against the model #1 later.
    task automatic applyStimulus(input logic [15:0] cmd, input logic valid, input logic [3:0] done);
        cmd_word     = cmd;
        cmd_valid    = valid;
        readout_done = done;
        @(posedge clk_in);
        modelStep(cmd, valid, done);
        #1;
        cmd_valid    = 1'b0;
        readout_done = 4'h0;
        checkModel();
    endtask

    task automatic idleSteps(input int n);
        for (int i = 0; i < n; i++) applyStimulus(mkCmd(0, 0), 1'b0, 4'h0);
    endtask

    task automatic waitPulse(input int budget, output int steps);
        steps = budget;
        for (int i = 1; i <= budget; i++) begin
            applyStimulus(mkCmd(0, 0), 1'b0, 4'h0);
            if (start_ch != 4'h0) begin
                steps = i;
                break;
            end
        end
    endtask

    initial begin
        int steps;
        int pulses;
        int ackDelay;
        int op;
        int val;
        logic vld;
        logic [3:0] d;

        reset        = 1'b1;
        cmd_word     = 16'h0;
        cmd_valid    = 1'b0;
        readout_done = 4'h0;
        edgeNum      = 0;
        mPulseAt     = 0;
        modelReset();

        // Reset state, observed before any clock edge.
        #2;
        checkOutput("reset_start_ch",    32'(start_ch),  32'h0);
        checkOutput("reset_running",     32'(running),   32'h0);
        checkOutput("reset_integ_count", integ_count,    32'd5000);
        checkOutput("reset_frame_count", frame_count,    32'h0);
        checkOutput("reset_cmd_error",   32'(cmd_error), 32'h0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        reset = 1'b0;

        // Single-cycle command vectors from the reset state.
        addVec("noop",          0, 0,       4'h0, 1'b0, 5000,  0, 1'b0);
        addVec("integ_zero",    3, 0,       4'h0, 1'b0, 1,     0, 1'b0);
        addVec("integ_max",     3, 'h1FFF,  4'h0, 1'b0, 32764, 0, 1'b0);
        addVec("integ_three",   3, 3,       4'h0, 1'b0, 12,    0, 1'b0);
        addVec("stop_idle",     2, 0,       4'h0, 1'b0, 12,    0, 1'b0);
        addVec("mask_zero",     5, 'h1F0,   4'h0, 1'b0, 12,    0, 1'b0);
        addVec("start_nomask",  1, 0,       4'h0, 1'b0, 12,    0, 1'b1);
        addVec("single_nomask", 6, 0,       4'h0, 1'b0, 12,    0, 1'b1);
        addVec("clr_err",       7, 0,       4'h0, 1'b0, 12,    0, 1'b0);
        addVec("mask_0101",     5, 'h0F5,   4'h0, 1'b0, 12,    0, 1'b0);
        addVec("frames_zero",   4, 0,       4'h0, 1'b0, 12,    0, 1'b0);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].cmd, vecs[i].valid, vecs[i].done);
            checkOutput({vecs[i].name, "_start_ch"},    32'(start_ch),  32'(vecs[i].expStart));
            checkOutput({vecs[i].name, "_running"},     32'(running),   32'(vecs[i].expRunning));
            checkOutput({vecs[i].name, "_integ_count"}, integ_count,    vecs[i].expInteg);
            checkOutput({vecs[i].name, "_frame_count"}, frame_count,    vecs[i].expFrames);
            checkOutput({vecs[i].name, "_cmd_error"},   32'(cmd_error), 32'(vecs[i].expErr));
        end

        // Single shot, integ 12, mask 0101: pulse integ+1 cycles after the
        // SINGLE cycle, i.e. on the 12th step after the SINGLE step.
        applyStimulus(mkCmd(6, 0), 1'b1, 4'h0);
        waitPulse(100, steps);
        checkOutput("single_latency", 32'(steps), 32'd12);
        checkOutput("single_start_ch", 32'(start_ch), 32'h5);
        applyStimulus(mkCmd(0, 0), 1'b0, 4'b0001);
        checkOutput("single_after_ch0_running", 32'(running), 32'h1);
        applyStimulus(mkCmd(0, 0), 1'b0, 4'b0100);
        checkOutput("single_after_ch2_running", 32'(running), 32'h0);
        checkOutput("single_frame_count", frame_count, 32'h1);

        // Finite run of three frames, acknowledged two cycles after each pulse.
        applyStimulus(mkCmd(3, 1), 1'b1, 4'h0);
        applyStimulus(mkCmd(4, 3), 1'b1, 4'h0);
        applyStimulus(mkCmd(1, 0), 1'b1, 4'h0);
        pulses   = 0;
        ackDelay = -1;
        for (int i = 0; i < 200; i++) begin
            d = (ackDelay == 0) ? 4'hF : 4'h0;
            if (ackDelay >= 0) ackDelay--;
            applyStimulus(mkCmd(0, 0), 1'b0, d);
            if (start_ch != 4'h0) begin
                pulses++;
                ackDelay = 1;
            end
            if (!running) break;
        end
        checkOutput("frames3_pulses", 32'(pulses), 32'd3);
        checkOutput("frames3_frame_count", frame_count, 32'd3);
        checkOutput("frames3_running", 32'(running), 32'h0);

        // Unlimited run stopped mid-integration: idle next cycle, no pulse.
        applyStimulus(mkCmd(4, 0), 1'b1, 4'h0);
        applyStimulus(mkCmd(1, 0), 1'b1, 4'h0);
        idleSteps(2);
        applyStimulus(mkCmd(2, 0), 1'b1, 4'h0);
        checkOutput("stop_integ_running", 32'(running), 32'h0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(mkCmd(0, 0), 1'b0, 4'h0);
            if (start_ch != 4'h0) pulses++;
        end
        checkOutput("stop_integ_pulses", 32'(pulses), 32'h0);

        // Unlimited run stopped mid-readout: the frame still completes.
        applyStimulus(mkCmd(1, 0), 1'b1, 4'h0);
        waitPulse(50, steps);
        checkOutput("stop_ro_latency", 32'(steps), 32'd4);
        applyStimulus(mkCmd(2, 0), 1'b1, 4'h0);
        checkOutput("stop_ro_still_running", 32'(running), 32'h1);
        applyStimulus(mkCmd(0, 0), 1'b0, 4'h5);
        checkOutput("stop_ro_running", 32'(running), 32'h0);
        checkOutput("stop_ro_frame_count", frame_count, 32'h1);

        // Illegal commands and error clearing.
        applyStimulus(mkCmd(1, 0), 1'b1, 4'h0);
        applyStimulus(mkCmd(3, 7), 1'b1, 4'h0);
        checkOutput("busy_setinteg_error", 32'(cmd_error), 32'h1);
        checkOutput("busy_setinteg_integ", integ_count, 32'd4);
        applyStimulus(mkCmd(2, 0), 1'b1, 4'h0);
        applyStimulus(mkCmd(7, 0), 1'b1, 4'h0);
        checkOutput("clr_err_after_busy", 32'(cmd_error), 32'h0);
        applyStimulus(mkCmd(5, 0), 1'b1, 4'h0);
        applyStimulus(mkCmd(1, 0), 1'b1, 4'h0);
        checkOutput("nomask_start_error", 32'(cmd_error), 32'h1);
        checkOutput("nomask_start_running", 32'(running), 32'h0);
        applyStimulus(mkCmd(7, 0), 1'b1, 4'h0);
        checkOutput("clr_err_nomask", 32'(cmd_error), 32'h0);
        applyStimulus(mkCmd(5, 5), 1'b1, 4'h0);

        // STOP on the terminal-count cycle suppresses the start pulse.
        applyStimulus(mkCmd(1, 0), 1'b1, 4'h0);
        idleSteps(3);
        applyStimulus(mkCmd(2, 0), 1'b1, 4'h0);
        checkOutput("stop_terminal_start_ch", 32'(start_ch), 32'h0);
        checkOutput("stop_terminal_running", 32'(running), 32'h0);
        idleSteps(3);

        // Asynchronous reset while channels are still pending in readout.
        applyStimulus(mkCmd(1, 0), 1'b1, 4'h0);
        applyStimulus(mkCmd(5, 3), 1'b1, 4'h0);
        waitPulse(50, steps);
        checkOutput("async_pre_start_ch", 32'(start_ch), 32'h5);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_start_ch",    32'(start_ch),  32'h0);
        checkOutput("async_running",     32'(running),   32'h0);
        checkOutput("async_integ_count", integ_count,    32'd5000);
        checkOutput("async_frame_count", frame_count,    32'h0);
        checkOutput("async_cmd_error",   32'(cmd_error), 32'h0);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        modelReset();
        applyStimulus(mkCmd(0, 0), 1'b0, 4'h0);
        checkOutput("post_reset_integ_count", integ_count, 32'd5000);

        // Randomized phase against the reference model.
        applyStimulus(mkCmd(3, 1), 1'b1, 4'h0);
        for (int i = 0; i < 1500; i++) begin
            vld = ($urandom_range(0, 99) < 12);
            op  = int'($urandom_range(0, 7));
            case (op)
                3:       val = int'($urandom_range(0, 3));
                4:       val = int'($urandom_range(0, 4));
                5:       val = int'($urandom_range(0, 15));
                default: val = int'($urandom_range(0, 8191));
            endcase
            d = ($urandom_range(0, 99) < 35) ? 4'($urandom_range(0, 15)) : 4'h0;
            applyStimulus(mkCmd(op, val), vld, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
